// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL bring-up sequencer: state encoding,
// phase-select width and the wrapping phase-step helper.
package pll_ctrl_pkg;

  localparam int PSDA_W = 4;

  typedef enum logic [2:0] {
    RESET_PLL    = 3'd0,
    WAIT_LOCK    = 3'd1,
    STABLE       = 3'd2,
    RUN          = 3'd3,
    PHASE_SETTLE = 3'd4,
    FAIL         = 3'd5
  } pll_state_e;

  // Phase select wraps modulo 2**PSDA_W in both directions
  function automatic logic [PSDA_W-1:0] psdaStep(input logic [PSDA_W-1:0] cur,
                                                 input logic              up);
    return up ? cur + 1'b1 : cur - 1'b1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer with synchronous reset, for asynchronous PLL lock inputs.
module lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      o_sync <= '0;
    end else begin
      r_meta <= i_async;
      o_sync <= r_meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// rPLL supervisor: pulses PLL reset, qualifies lock with timeout/retry,
// gates the video-domain reset and steps the CLKOUTP phase select.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned         RESET_PULSE_CYCLES  = 16,
  parameter int unsigned         LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned         LOCK_TIMEOUT_CYCLES = 270000,
  parameter int unsigned         MAX_RETRIES         = 3,
  parameter int unsigned         PS_SETTLE_CYCLES    = 256,
  parameter logic [PSDA_W-1:0]   PSDA_INIT           = 4'b0000,
  parameter int unsigned         CNT_W               = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock_i,
  output logic              pll_reset_o,
  output logic [PSDA_W-1:0] psda_o,
  input  logic              ps_req_i,
  input  logic              ps_dir_i,
  output logic              ps_ack_o,
  output logic              user_rst_o,
  output logic              clk_ok_o,
  output logic              lock_lost_o,
  output logic              fail_o,
  output logic [1:0]        retry_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PS_SETTLE_CYCLES - 1);
  localparam logic [1:0]       MAX_RET     = 2'(MAX_RETRIES);

  logic       w_lockS;
  pll_state_e r_state;
  logic [CNT_W-1:0] r_seqCnt;
  logic [CNT_W-1:0] r_tmoCnt;
  logic [CNT_W-1:0] r_stbCnt;

  lock_sync #(.WIDTH(1)) u_lockSync (
    .clk     (clk),
    .rst     (rst),
    .i_async (pll_lock_i),
    .o_sync  (w_lockS)
  );

  // r_seqCnt times both the reset pulse and the post-step settle window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RESET_PLL;
      pll_reset_o <= 1'b1;
      user_rst_o  <= 1'b1;
      clk_ok_o    <= 1'b0;
      psda_o      <= PSDA_INIT;
      ps_ack_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      fail_o      <= 1'b0;
      retry_cnt_o <= 2'd0;
      r_seqCnt    <= '0;
      r_tmoCnt    <= '0;
      r_stbCnt    <= '0;
    end else begin
      ps_ack_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      case (r_state)
        RESET_PLL: begin
          if (r_seqCnt == RST_LAST) begin
            r_state     <= WAIT_LOCK;
            pll_reset_o <= 1'b0;
            r_seqCnt    <= '0;
            r_tmoCnt    <= '0;
            r_stbCnt    <= '0;
          end else begin
            r_seqCnt <= r_seqCnt + 1'b1;
          end
        end

        // Timeout keeps running across lock chatter; stable completion beats it
        WAIT_LOCK, STABLE: begin
          r_tmoCnt <= r_tmoCnt + 1'b1;
          if (r_state == STABLE && w_lockS && r_stbCnt == STB_LAST) begin
            r_state     <= RUN;
            user_rst_o  <= 1'b0;
            clk_ok_o    <= 1'b1;
            retry_cnt_o <= 2'd0;
          end else if (r_tmoCnt == TMO_LAST) begin
            pll_reset_o <= 1'b1;
            r_seqCnt    <= '0;
            if (retry_cnt_o < MAX_RET) begin
              retry_cnt_o <= retry_cnt_o + 2'd1;
              r_state     <= RESET_PLL;
            end else begin
              fail_o  <= 1'b1;
              r_state <= FAIL;
            end
          end else if (!w_lockS) begin
            r_state  <= WAIT_LOCK;
            r_stbCnt <= '0;
          end else if (r_state == STABLE) begin
            r_stbCnt <= r_stbCnt + 1'b1;
          end else begin
            r_state <= STABLE;
          end
        end

        RUN, PHASE_SETTLE: begin
          if (!w_lockS) begin
            r_state     <= RESET_PLL;
            lock_lost_o <= 1'b1;
            user_rst_o  <= 1'b1;
            clk_ok_o    <= 1'b0;
            pll_reset_o <= 1'b1;
            retry_cnt_o <= 2'd0;
            r_seqCnt    <= '0;
          end else if (r_state == RUN) begin
            if (ps_req_i) begin
              r_state  <= PHASE_SETTLE;
              psda_o   <= psdaStep(psda_o, ps_dir_i);
              ps_ack_o <= 1'b1;
              clk_ok_o <= 1'b0;
              r_seqCnt <= '0;
            end
          end else if (r_seqCnt == SETTLE_LAST) begin
            r_state  <= RUN;
            clk_ok_o <= 1'b1;
            r_seqCnt <= '0;
          end else begin
            r_seqCnt <= r_seqCnt + 1'b1;
          end
        end

        FAIL: begin
          pll_reset_o <= 1'b1;
          user_rst_o  <= 1'b1;
          clk_ok_o    <= 1'b0;
          fail_o      <= 1'b1;
        end

        default: begin
          r_state     <= RESET_PLL;
          pll_reset_o <= 1'b1;
          user_rst_o  <= 1'b1;
          clk_ok_o    <= 1'b0;
          r_seqCnt    <= '0;
        end
      endcase
    end
  end

endmodule
